issue_scheduler: RTL

ISSUE_SCHEDULER -- requirements
Module: issue_scheduler

---
 rtl/issue_scheduler_pkg.sv | 31 +++
 rtl/issue_scheduler_rr_arbiter.sv | 44 ++++
 rtl/issue_scheduler.sv | 82 ++++++++
 3 files changed

// File: rtl/issue_scheduler_pkg.sv
// Shared types and writeback-latency constants for the issue scheduler.
// thread_idx_t is 2 bits wide, so designs that use this package support at most 4 threads.
package issue_scheduler_pkg;

  localparam int THREAD_IDX_W = 2;
  typedef logic [THREAD_IDX_W-1:0] thread_idx_t;

  typedef enum logic [1:0] {
    PIPE_INT   = 2'd0,
    PIPE_MEM   = 2'd1,
    PIPE_FLOAT = 2'd2
  } pipeline_sel_t;

  localparam int INT_LATENCY    = 3;
  localparam int MEM_LATENCY    = 4;
  localparam int FLOAT_LATENCY  = 7;
  localparam int MAX_WB_LATENCY = 7;

  localparam int LAT_W = 3;
  typedef logic [LAT_W-1:0] latency_t;

  // The unused encoding falls back to the shortest latency.
  function automatic latency_t pipe_latency(input pipeline_sel_t pipe);
    case (pipe)
      PIPE_MEM:   return latency_t'(MEM_LATENCY);
      PIPE_FLOAT: return latency_t'(FLOAT_LATENCY);
      default:    return latency_t'(INT_LATENCY);
    endcase
  endfunction

endpackage

// File: rtl/issue_scheduler_rr_arbiter.sv
// Round-robin arbiter that starts its search one past the previous winner.
// The pointer advances only when a request is granted and update_en is high.
module rr_arbiter
  import issue_scheduler_pkg::*;
#(
  parameter int N = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [N-1:0] req,
  input  logic        update_en,
  output logic [N-1:0] grant,
  output thread_idx_t grant_idx
);

  thread_idx_t last_grant;

  always_comb begin
    logic found;
    int   cand;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int i = 1; i <= N; i++) begin
      cand = (int'(last_grant) + i) % N;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = thread_idx_t'(cand);
      end
    end
  end

  // After reset, the pointer is set to N-1 so that thread 0 wins first.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= thread_idx_t'(N - 1);
    end else if (update_en && (|req)) begin
      last_grant <= grant_idx;
    end
  end

endmodule

// File: rtl/issue_scheduler.sv
// Per-cycle instruction issue scheduler: it grants one thread by round robin.
// The writeback port is reserved ahead of time, so pipelines of different latencies never collide.
module issue_scheduler
  import issue_scheduler_pkg::*;
#(
  parameter int NUM_THREADS = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic          [NUM_THREADS-1:0] thread_en,
  input  logic          [NUM_THREADS-1:0] thread_ready,
  input  logic          [NUM_THREADS-1:0] scoreboard_can_issue,
  input  pipeline_sel_t [NUM_THREADS-1:0] thread_pipeline,
  input  logic                           rollback_en,
  input  thread_idx_t                    rollback_thread,
  output logic          [NUM_THREADS-1:0] will_issue,
  output logic                           issue_valid,
  output thread_idx_t                    issue_thread,
  output pipeline_sel_t                  issue_pipeline
);

  // When wb_slot[k] is set, the writeback port is already claimed k cycles from now.
  logic [MAX_WB_LATENCY:1] wb_slot;
  logic [MAX_WB_LATENCY:1] wb_slot_next;

  latency_t               thread_lat [NUM_THREADS];
  logic [NUM_THREADS-1:0] eligible;
  logic [NUM_THREADS-1:0] grant;
  thread_idx_t            grant_idx;
  logic                   grant_any;
  latency_t               granted_lat;

  always_comb begin
    for (int t = 0; t < NUM_THREADS; t++) begin
      thread_lat[t] = pipe_latency(thread_pipeline[t]);
      eligible[t]   = thread_en[t] & thread_ready[t] & scoreboard_can_issue[t]
                    & ~(rollback_en && (rollback_thread == thread_idx_t'(t)))
                    & ~wb_slot[thread_lat[t]]
                    & ~reset;
    end
  end

  rr_arbiter #(
    .N (NUM_THREADS)
  ) u_rr_arbiter (
    .clk       (clk),
    .reset     (reset),
    .req       (eligible),
    .update_en (~reset),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign will_issue  = grant;
  assign grant_any   = |grant;
  assign granted_lat = thread_lat[grant_idx];

  // Each cycle, the reservations shift one step closer. The new grant claims its own writeback cycle.
  always_comb begin
    wb_slot_next = '0;
    for (int k = 1; k < MAX_WB_LATENCY; k++) begin
      wb_slot_next[k] = wb_slot[k+1] | (grant_any && (granted_lat == latency_t'(k + 1)));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_slot        <= '0;
      issue_valid    <= 1'b0;
      issue_thread   <= '0;
      issue_pipeline <= PIPE_INT;
    end else begin
      wb_slot     <= wb_slot_next;
      issue_valid <= grant_any;
      if (grant_any) begin
        issue_thread   <= grant_idx;
        issue_pipeline <= thread_pipeline[grant_idx];
      end
    end
  end

endmodule
